// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose: operand forwarding and hazard detection for an in-order pipeline
// that also hosts a single fixed-latency multi-cycle unit.
//   * Forwards MEM- or WB-stage results onto the EX operands.
//   * Detects load-use hazards and hazards against an in-flight multi-cycle op.
//   * Tracks the multi-cycle unit with an IDLE/BUSY/DONE state machine.
//   * Counts stall cycles in a saturating counter.
//
// Parameters:
//   XLEN   datapath width
//   NREAD  number of register read ports (packed, port 0 in the LSBs)
//   MC_LAT multi-cycle unit latency in cycles (2..16)
//   CNT_W  stall counter width
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid/id_rs/id_mc  decode-stage instruction, sources, multi-cycle flag
//   ex_rs/ex_rdata        EX-stage source indices and register file values
//   id_ex_*               EX-stage destination, write enable, load flag
//   ex_mem_*              MEM-stage destination, write enable, ALU result
//   mem_wb_*              WB-stage destination, write enable, data select, data
//   mc_issue/mc_rd        multi-cycle op leaving EX and its destination
//   fwd_data              forwarded EX operands
//   stall/flush_ex        combinational hold of PC+IF/ID and ID/EX bubble
//   mc_busy/mc_done       unit occupied / registered completion pulse
//   mc_err                sticky: issue seen while the unit was BUSY
//   stall_cnt             saturating stall-cycle counter
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int XLEN   = 32,
    parameter int NREAD  = 2,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [NREAD*5-1:0]      id_rs,
    input  logic                    id_mc,
    input  logic [NREAD*5-1:0]      ex_rs,
    input  logic [NREAD*XLEN-1:0]   ex_rdata,
    input  logic [4:0]              id_ex_rd,
    input  logic                    id_ex_rw,
    input  logic                    id_ex_load,
    input  logic [4:0]              ex_mem_rd,
    input  logic                    ex_mem_rw,
    input  logic [XLEN-1:0]         ex_mem_result,
    input  logic [4:0]              mem_wb_rd,
    input  logic                    mem_wb_rw,
    input  logic                    mem_wb_to_reg,
    input  logic [XLEN-1:0]         mem_wb_rdata,
    input  logic [XLEN-1:0]         mem_wb_result,
    input  logic                    mc_issue,
    input  logic [4:0]              mc_rd,
    output logic [NREAD*XLEN-1:0]   fwd_data,
    output logic                    stall,
    output logic                    flush_ex,
    output logic                    mc_busy,
    output logic                    mc_done,
    output logic                    mc_err,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_M1 = 4'(MC_LAT - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [4:0]       r_pend_rd;
    logic             r_mc_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [XLEN-1:0]  w_wb_val;
    logic             w_lu_match;
    logic             w_mc_match;
    logic             w_load_use;
    logic             w_mc_haz;
    logic             w_busy;

    // ---------------- Forwarding ----------------
    assign w_wb_val = mem_wb_to_reg ? mem_wb_rdata : mem_wb_result;

    // MEM has priority over WB because it holds the younger result.
    always_comb begin
        fwd_data = ex_rdata;
        for (int i = 0; i < NREAD; i++) begin
            if (ex_mem_rw && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rs[i*5 +: 5])) begin
                fwd_data[i*XLEN +: XLEN] = ex_mem_result;
            end else if (mem_wb_rw && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rs[i*5 +: 5])) begin
                fwd_data[i*XLEN +: XLEN] = w_wb_val;
            end
        end
    end

    // ---------------- Hazard detection ----------------
    always_comb begin
        w_lu_match = 1'b0;
        w_mc_match = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (id_rs[i*5 +: 5] == id_ex_rd)  w_lu_match = 1'b1;
            if (id_rs[i*5 +: 5] == r_pend_rd) w_mc_match = 1'b1;
        end
    end

    assign w_busy     = (r_state != S_IDLE);
    assign w_load_use = id_valid & id_ex_load & id_ex_rw & (id_ex_rd != 5'd0) & w_lu_match;
    // Gated by rst_n so the multi-cycle term is inert while reset is held.
    assign w_mc_haz   = rst_n & id_valid & w_busy &
                        (id_mc | ((r_pend_rd != 5'd0) & w_mc_match));

    assign stall    = w_load_use | w_mc_haz;
    assign flush_ex = stall;

    // ---------------- Multi-cycle unit tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pend_rd <= 5'd0;
            r_mc_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (mc_issue) begin
                        r_pend_rd <= mc_rd;
                        r_cnt     <= LAT_M1;
                        r_state   <= S_BUSY;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // A second issue while busy is an error and does not disturb timing.
                    if (mc_issue) r_mc_err <= 1'b1;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mc_busy = w_busy;
    assign mc_done = (r_state == S_DONE);
    assign mc_err  = r_mc_err;

    // ---------------- Stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int XLEN   = 32;
    localparam int NREAD  = 2;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic                  id_valid;
        logic [NREAD*5-1:0]    id_rs;
        logic                  id_mc;
        logic [NREAD*5-1:0]    ex_rs;
        logic [NREAD*XLEN-1:0] ex_rdata;
        logic [4:0]            id_ex_rd;
        logic                  id_ex_rw;
        logic                  id_ex_load;
        logic [4:0]            ex_mem_rd;
        logic                  ex_mem_rw;
        logic [XLEN-1:0]       ex_mem_result;
        logic [4:0]            mem_wb_rd;
        logic                  mem_wb_rw;
        logic                  mem_wb_to_reg;
        logic [XLEN-1:0]       mem_wb_rdata;
        logic [XLEN-1:0]       mem_wb_result;
        logic                  mc_issue;
        logic [4:0]            mc_rd;
    } stim_t;

    typedef struct packed {
        logic [NREAD*XLEN-1:0] fwd;
        logic                  stall;
        logic                  busy;
        logic                  done;
        logic                  err;
        logic [CNT_W-1:0]      cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic                  id_valid, id_mc, id_ex_rw, id_ex_load, ex_mem_rw;
    logic                  mem_wb_rw, mem_wb_to_reg, mc_issue;
    logic [NREAD*5-1:0]    id_rs, ex_rs;
    logic [NREAD*XLEN-1:0] ex_rdata, fwd_data;
    logic [4:0]            id_ex_rd, ex_mem_rd, mem_wb_rd, mc_rd;
    logic [XLEN-1:0]       ex_mem_result, mem_wb_rdata, mem_wb_result;
    logic                  stall, flush_ex, mc_busy, mc_done, mc_err;
    logic [CNT_W-1:0]      stall_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.XLEN(XLEN), .NREAD(NREAD), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_mc(id_mc),
        .ex_rs(ex_rs), .ex_rdata(ex_rdata),
        .id_ex_rd(id_ex_rd), .id_ex_rw(id_ex_rw), .id_ex_load(id_ex_load),
        .ex_mem_rd(ex_mem_rd), .ex_mem_rw(ex_mem_rw), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_rw(mem_wb_rw), .mem_wb_to_reg(mem_wb_to_reg),
        .mem_wb_rdata(mem_wb_rdata), .mem_wb_result(mem_wb_result),
        .mc_issue(mc_issue), .mc_rd(mc_rd),
        .fwd_data(fwd_data), .stall(stall), .flush_ex(flush_ex),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    // Reference model: remaining occupancy of the multi-cycle unit, counting
    // the completion cycle as the last one (value 1).
    int          m_left;
    logic [4:0]  m_pend;
    logic        m_err;
    int          m_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   drv_done = 0;

    function automatic exp_t model_expect(input stim_t s, input logic rst);
        exp_t e;
        bit   lu_hit, mc_hit;
        logic [4:0] r;
        e.fwd = s.ex_rdata;
        for (int i = 0; i < NREAD; i++) begin
            r = s.ex_rs[i*5 +: 5];
            if (r != 0 && s.ex_mem_rw && s.ex_mem_rd == r)
                e.fwd[i*XLEN +: XLEN] = s.ex_mem_result;
            else if (r != 0 && s.mem_wb_rw && s.mem_wb_rd == r)
                e.fwd[i*XLEN +: XLEN] = s.mem_wb_to_reg ? s.mem_wb_rdata : s.mem_wb_result;
        end
        lu_hit = 0;
        mc_hit = 0;
        for (int i = 0; i < NREAD; i++) begin
            r = s.id_rs[i*5 +: 5];
            if (r != 0 && r == s.id_ex_rd) lu_hit = 1;
            if (r != 0 && r == m_pend)     mc_hit = 1;
        end
        e.busy  = rst && (m_left > 0);
        e.done  = rst && (m_left == 1);
        e.err   = rst && m_err;
        e.cnt   = rst ? CNT_W'(m_cnt) : '0;
        e.stall = (s.id_valid && s.id_ex_load && s.id_ex_rw && lu_hit) ||
                  (rst && s.id_valid && e.busy && (s.id_mc || mc_hit));
        return e;
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_pend = 0;
        m_err  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input stim_t s, input exp_t e);
        if (s.mc_issue && m_left > 1) m_err = 1;
        if (m_left <= 1) begin
            if (s.mc_issue) begin
                m_left = MC_LAT;
                m_pend = s.mc_rd;
            end else begin
                m_left = 0;
            end
        end else begin
            m_left = m_left - 1;
        end
        if (e.stall && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    endtask

    task automatic run(input stim_t s, input logic rst);
        exp_t e;
        @(negedge clk);
        id_valid = s.id_valid; id_rs = s.id_rs; id_mc = s.id_mc;
        ex_rs = s.ex_rs; ex_rdata = s.ex_rdata;
        id_ex_rd = s.id_ex_rd; id_ex_rw = s.id_ex_rw; id_ex_load = s.id_ex_load;
        ex_mem_rd = s.ex_mem_rd; ex_mem_rw = s.ex_mem_rw; ex_mem_result = s.ex_mem_result;
        mem_wb_rd = s.mem_wb_rd; mem_wb_rw = s.mem_wb_rw; mem_wb_to_reg = s.mem_wb_to_reg;
        mem_wb_rdata = s.mem_wb_rdata; mem_wb_result = s.mem_wb_result;
        mc_issue = s.mc_issue; mc_rd = s.mc_rd;
        rst_n = rst;
        if (!rst) model_reset();
        e = model_expect(s, rst);
        q.push_back(e);
        @(posedge clk);
        if (rst) model_step(s, e);
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.id_valid      = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NREAD; i++) begin
            s.id_rs[i*5 +: 5] = rreg();
            s.ex_rs[i*5 +: 5] = rreg();
            s.ex_rdata[i*XLEN +: XLEN] = $urandom;
        end
        s.id_mc         = ($urandom_range(0, 4) == 0);
        s.id_ex_rd      = rreg();
        s.id_ex_rw      = $urandom_range(0, 1);
        s.id_ex_load    = $urandom_range(0, 1);
        s.ex_mem_rd     = rreg();
        s.ex_mem_rw     = $urandom_range(0, 1);
        s.ex_mem_result = $urandom;
        s.mem_wb_rd     = rreg();
        s.mem_wb_rw     = $urandom_range(0, 1);
        s.mem_wb_to_reg = $urandom_range(0, 1);
        s.mem_wb_rdata  = $urandom;
        s.mem_wb_result = $urandom;
        s.mc_issue      = ($urandom_range(0, 5) == 0);
        s.mc_rd         = rreg();
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: pops one expectation per presented cycle.
    initial begin : monitor
        exp_t e;
        while (!(drv_done && q.size() == 0)) begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < NREAD; i++)
                    chk($sformatf("fwd_data[%0d]", i), 64'(fwd_data[i*XLEN +: XLEN]), 64'(e.fwd[i*XLEN +: XLEN]));
                chk("stall",     64'(stall),     64'(e.stall));
                chk("flush_ex",  64'(flush_ex),  64'(e.stall));
                chk("mc_busy",   64'(mc_busy),   64'(e.busy));
                chk("mc_done",   64'(mc_done),   64'(e.done));
                chk("mc_err",    64'(mc_err),    64'(e.err));
                chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Driver
    initial begin : driver
        stim_t s;
        model_reset();
        s = '0;
        run(s, 1'b0);
        run(s, 1'b0);

        // MEM beats WB on the same register
        s = '0;
        s.ex_mem_rw = 1; s.ex_mem_rd = 5; s.ex_mem_result = 32'hAAAA0000;
        s.mem_wb_rw = 1; s.mem_wb_rd = 5; s.mem_wb_result = 32'h5555;
        s.ex_rs[4:0] = 5; s.ex_rdata = {32'h1111, 32'h2222};
        run(s, 1'b1);

        // WB load-data select, then x0 never forwarded
        s = '0;
        s.mem_wb_rw = 1; s.mem_wb_rd = 7; s.mem_wb_to_reg = 1;
        s.mem_wb_rdata = 32'h1234; s.mem_wb_result = 32'h9999;
        s.ex_rs[9:5] = 7; s.ex_rdata = {32'h3333, 32'h4444};
        run(s, 1'b1);
        s.ex_rs[9:5] = 0; s.mem_wb_rd = 0;
        run(s, 1'b1);

        // Load-use on read port 1
        s = '0;
        s.id_valid = 1; s.id_ex_load = 1; s.id_ex_rw = 1; s.id_ex_rd = 3; s.id_rs[9:5] = 3;
        run(s, 1'b1);
        s = '0;
        run(s, 1'b1);

        // Multi-cycle op to x9: dependent decode stalls, independent does not
        s = '0; s.mc_issue = 1; s.mc_rd = 9;
        run(s, 1'b1);
        s = '0; s.id_valid = 1; s.id_rs[4:0] = 9;
        for (int k = 0; k < MC_LAT + 1; k++) run(s, 1'b1);
        s = '0; s.mc_issue = 1; s.mc_rd = 9;
        run(s, 1'b1);
        s = '0; s.id_valid = 1; s.id_rs[4:0] = 8;
        for (int k = 0; k < MC_LAT + 1; k++) run(s, 1'b1);

        // Issue while busy: sticky error, timing unchanged
        s = '0; s.mc_issue = 1; s.mc_rd = 4;
        run(s, 1'b1);
        s.mc_rd = 6;
        run(s, 1'b1);
        s = '0;
        for (int k = 0; k < MC_LAT + 1; k++) run(s, 1'b1);

        // Reset asserted mid-busy, checked before the next clock edge
        s = '0; s.mc_issue = 1; s.mc_rd = 12;
        run(s, 1'b1);
        s = '0;
        run(s, 1'b1);
        run(s, 1'b0);
        run(s, 1'b1);

        // Stall held 20 cycles saturates the counter
        s = '0;
        s.id_valid = 1; s.id_ex_load = 1; s.id_ex_rw = 1; s.id_ex_rd = 2; s.id_rs[4:0] = 2;
        for (int k = 0; k < 20; k++) run(s, 1'b1);
        #1;
        chk("stall_cnt_saturated", 64'(stall_cnt), 64'hF);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            s = rand_stim();
            run(s, ($urandom_range(0, 49) != 0));
        end
        drv_done = 1;
    end

endmodule
